// File: rtl/bnn_layer_sequencer_if.sv
// bnn_layer_sequencer_if: control and memory bus between the layer sequencer and its memories
interface bnn_layer_sequencer_if #(
  parameter int W_ADDR_LEN = 22,
  parameter int X_ADDR_LEN = 10
);
  logic start;
  logic busy;
  logic done;
  logic [1:0] layer;
  logic w_rd;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic w_data;
  logic x_rd;
  logic [1:0] x_rd_sel;
  logic [X_ADDR_LEN-1:0] x_rd_addr;
  logic x_data;
  logic x_we;
  logic [1:0] x_wr_sel;
  logic [X_ADDR_LEN-1:0] x_wr_addr;
  logic x_wdata;
  modport master (
    input start, w_data, x_data,
    output busy, done, layer, w_rd, w_addr, x_rd, x_rd_sel, x_rd_addr,
    output x_we, x_wr_sel, x_wr_addr, x_wdata
  );
  modport slave (
    output start, w_data, x_data,
    input busy, done, layer, w_rd, w_addr, x_rd, x_rd_sel, x_rd_addr,
    input x_we, x_wr_sel, x_wr_addr, x_wdata
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: walks four XNOR/popcount layers, streaming weights/activations and writing sign bits back
module bnn_layer_sequencer #(
  parameter int N_IN = 784,
  parameter int N_HID = 1024,
  parameter int N_OUT = 10,
  parameter int W_ADDR_LEN = 22,
  parameter int X_ADDR_LEN = 10,
  parameter int alu_width = 12
) (
  input logic clk,
  input logic rst,
  bnn_layer_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_layer;
  logic [X_ADDR_LEN-1:0] r_neuron, r_i;
  logic [W_ADDR_LEN-1:0] r_w_addr;
  logic [alu_width-1:0] r_acc, w_fan_in, w_n_neu;
  logic r_vld, w_last_i, w_last_n, w_act, w_match;
  assign w_fan_in = r_layer == 2'd0 ? alu_width'(N_IN) : alu_width'(N_HID);
  assign w_n_neu = r_layer == 2'd3 ? alu_width'(N_OUT) : alu_width'(N_HID);
  assign w_last_i = alu_width'(r_i) == w_fan_in - 1'b1;
  assign w_last_n = alu_width'(r_neuron) == w_n_neu - 1'b1;
  assign w_act = {r_acc, 1'b0} >= {1'b0, w_fan_in};
  assign w_match = ~(bus.w_data ^ bus.x_data);
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.start ? RUN : IDLE;
      RUN: w_next = w_last_i ? DRAIN : RUN;
      DRAIN: w_next = WRITE;
      WRITE: w_next = (!w_last_n || r_layer != 2'd3) ? RUN : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_layer <= '0;
      r_neuron <= '0;
      r_i <= '0;
      r_w_addr <= '0;
      r_acc <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= r_state == RUN;
      r_acc <= (r_state == WRITE || r_state == IDLE) ? '0 :
               r_vld ? r_acc + {{(alu_width-1){1'b0}}, w_match} : r_acc;
      if (r_state == IDLE && bus.start) begin
        r_layer <= '0;
        r_neuron <= '0;
        r_i <= '0;
        r_w_addr <= '0;
      end else if (r_state == RUN) begin
        r_i <= r_i + 1'b1;
        r_w_addr <= r_w_addr + 1'b1;
      end else if (r_state == WRITE) begin
        r_i <= '0;
        r_neuron <= w_last_n ? '0 : r_neuron + 1'b1;
        if (w_last_n) r_layer <= r_layer + 1'b1;
      end
    end
  end
  assign bus.busy = r_state == RUN || r_state == DRAIN || r_state == WRITE;
  assign bus.done = r_state == DONE;
  assign bus.layer = r_layer;
  assign bus.w_rd = r_state == RUN;
  assign bus.w_addr = r_w_addr;
  assign bus.x_rd = r_state == RUN;
  assign bus.x_rd_sel = bus.busy ? (r_layer == 2'd3 ? 2'd1 : r_layer) : 2'd0;
  assign bus.x_rd_addr = r_i;
  assign bus.x_we = r_state == WRITE;
  assign bus.x_wr_sel = r_state != WRITE ? 2'd0 : r_layer == 2'd3 ? 2'd3 : r_layer == 2'd1 ? 2'd2 : 2'd1;
  assign bus.x_wr_addr = r_neuron;
  assign bus.x_wdata = r_state == WRITE && w_act;
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// tb_bnn_layer_sequencer: directed checks of the layer sequencer in a 4/3/3/3/2 configuration
module tb_bnn_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  logic wmem [36];
  logic xin [4];
  logic xh [4][4];
  logic [1:0] we_sel [$];
  logic we_dat [$];
  logic [5:0] wa_q [$];
  logic [1:0] ra_q [$];
  logic [1:0] rs_q [$];
  logic [1:0] rl_q [$];
  always #5 clk = ~clk;
  bnn_layer_sequencer_if #(.W_ADDR_LEN(6), .X_ADDR_LEN(2)) bus ();
  bnn_layer_sequencer #(
    .N_IN(4), .N_HID(3), .N_OUT(2), .W_ADDR_LEN(6), .X_ADDR_LEN(2), .alu_width(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always @(posedge clk) begin
    if (bus.w_rd === 1'b1) bus.w_data <= wmem[bus.w_addr];
    if (bus.x_rd === 1'b1) bus.x_data <= bus.x_rd_sel == 2'd0 ? xin[bus.x_rd_addr] : xh[bus.x_rd_sel][bus.x_rd_addr];
    if (bus.x_we === 1'b1) xh[bus.x_wr_sel][bus.x_wr_addr] <= bus.x_wdata;
  end
  always @(negedge clk) begin
    if (bus.x_we === 1'b1) begin
      we_sel.push_back(bus.x_wr_sel);
      we_dat.push_back(bus.x_wdata);
      if (bus.x_rd === 1'b1) overlap++;
    end
    if (bus.w_rd === 1'b1) begin
      wa_q.push_back(bus.w_addr);
      ra_q.push_back(bus.x_rd_addr);
      rs_q.push_back(bus.x_rd_sel);
      rl_q.push_back(bus.layer);
    end
  end
  function automatic logic [21:0] outs();
    return {bus.busy, bus.done, bus.layer, bus.w_rd, bus.w_addr, bus.x_rd, bus.x_rd_sel,
            bus.x_rd_addr, bus.x_we, bus.x_wr_sel, bus.x_wr_addr, bus.x_wdata};
  endfunction
  task automatic set_mem(input logic [35:0] w, input logic [3:0] x);
    for (int j = 0; j < 36; j++) wmem[j] = w[j];
    for (int j = 0; j < 4; j++) xin[j] = x[j];
  endtask
  task automatic do_run(input int pulse_at, input int rst_at, output int bc, output int dk, output int nd);
    bc = 0;
    dk = 0;
    nd = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) begin
        nd++;
        if (dk == 0) dk = k;
      end
      bus.start = k == pulse_at;
      if (k == rst_at) begin
        rst = 1'b0;
        break;
      end
      if (dk != 0 && k >= dk + 3) break;
      @(negedge clk);
    end
  endtask
  task automatic check_sweep(input int b, input string tag);
    int n, bad_a, bad_r, bad_s, el;
    n = wa_q.size() - b;
    bad_a = 0;
    bad_r = 0;
    bad_s = 0;
    checks++;
    if (n !== 36) begin
      failures++;
      $display("FAIL %s_read_count: got %0d expected 36", tag, n);
    end
    for (int j = 0; j < n && j < 36; j++) begin
      el = j < 12 ? 0 : j < 21 ? 1 : j < 30 ? 2 : 3;
      if (wa_q[b+j] !== 6'(j)) bad_a++;
      if (ra_q[b+j] !== 2'(j < 12 ? j % 4 : (j - 12) % 3) || rl_q[b+j] !== 2'(el)) bad_r++;
      if (rs_q[b+j] !== 2'(el == 3 ? 1 : el)) bad_s++;
    end
    checks++;
    if (bad_a !== 0) begin
      failures++;
      $display("FAIL %s_w_addr: got %0d bad beats expected 0", tag, bad_a);
    end
    checks++;
    if (bad_r !== 0) begin
      failures++;
      $display("FAIL %s_x_rd_addr: got %0d bad beats expected 0", tag, bad_r);
    end
    checks++;
    if (bad_s !== 0) begin
      failures++;
      $display("FAIL %s_x_rd_sel: got %0d bad beats expected 0", tag, bad_s);
    end
  endtask
  task automatic check_timing(input int bc, input int dk, input int nd, input string tag);
    checks++;
    if (bc !== 58) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d expected 58", tag, bc);
    end
    checks++;
    if (dk !== 59) begin
      failures++;
      $display("FAIL %s_done_cycle: got %0d expected 59", tag, dk);
    end
    checks++;
    if (nd !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected 1", tag, nd);
    end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (outs() !== 22'd0) begin
        failures++;
        $display("FAIL reset_outputs: got %h expected 0", outs());
      end
    end
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask
  task automatic test_all_ones;
    int b, bc, dk, nd;
    logic [21:0] s;
    logic [10:0] d;
    set_mem('1, '1);
    b = we_sel.size();
    do_run(0, 0, bc, dk, nd);
    check_timing(bc, dk, nd, "ones");
    checks++;
    if (we_sel.size() - b !== 11) begin
      failures++;
      $display("FAIL ones_we_count: got %0d expected 11", we_sel.size() - b);
    end
    s = '0;
    d = '0;
    for (int j = 0; j < 11 && b + j < we_sel.size(); j++) begin
      s = {s[19:0], we_sel[b+j]};
      d = {d[9:0], we_dat[b+j]};
    end
    checks++;
    if (s !== 22'b01_01_01_10_10_10_01_01_01_11_11) begin
      failures++;
      $display("FAIL ones_wr_banks: got %b expected 0101011010100101011111", s);
    end
    checks++;
    if (d !== 11'h7FF) begin
      failures++;
      $display("FAIL ones_wdata: got %b expected 11111111111", d);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL ones_rd_wr_overlap: got %0d expected 0", overlap);
    end
  endtask
  task automatic test_addr_sweep;
    int b, bc, dk, nd;
    set_mem('1, '1);
    b = wa_q.size();
    do_run(0, 0, bc, dk, nd);
    check_sweep(b, "sweep");
  endtask
  task automatic test_threshold;
    int b, bc, dk, nd;
    logic [10:0] d;
    set_mem({24'hFFFFFF, 12'h013}, 4'hF);
    b = we_dat.size();
    do_run(0, 0, bc, dk, nd);
    d = '0;
    for (int j = 0; j < 11 && b + j < we_dat.size(); j++) d = {d[9:0], we_dat[b+j]};
    checks++;
    if (d[10:8] !== 3'b100) begin
      failures++;
      $display("FAIL thresh_layer0: got %b expected 100", d[10:8]);
    end
    checks++;
    if (d !== 11'b100_0000_0000) begin
      failures++;
      $display("FAIL thresh_all_layers: got %b expected 10000000000", d);
    end
  endtask
  task automatic test_start_busy;
    int b, bc, dk, nd;
    set_mem('1, '1);
    b = wa_q.size();
    do_run(20, 0, bc, dk, nd);
    check_timing(bc, dk, nd, "busy_start");
    check_sweep(b, "busy_start");
  endtask
  task automatic test_reset_mid;
    int b, bc, dk, nd;
    set_mem('1, '1);
    do_run(0, 25, bc, dk, nd);
    checks++;
    if (bus.layer !== 2'd1) begin
      failures++;
      $display("FAIL midrst_layer: got %0d expected 1", bus.layer);
    end
    @(negedge clk);
    checks++;
    if (outs() !== 22'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h expected 0", outs());
    end
    rst = 1'b1;
    b = wa_q.size();
    do_run(0, 0, bc, dk, nd);
    check_timing(bc, dk, nd, "midrst");
    check_sweep(b, "midrst");
  endtask
  initial begin
    bus.start = 1'b0;
    set_mem('1, '1);
    test_reset;
    test_all_ones;
    test_addr_sweep;
    test_threshold;
    test_start_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
